and_gate_sequencer: RTL and testbench

- Self-checking controller that sequences stimulus through the two-input AND gate datapath (and_gate, ports a/b/y) and checks its output in hardware.
- Runs an exhaustive phase over all four input combinations, then a pseudo-random phase.
- Compares y against a & b for every vector and reports pass/fail plus an error count.
- Sits beside and_gate on the board top; start comes from a debounced key, and pass/done drive LEDs.

---
 rtl/and_gate_sequencer.sv | 170 +++++++++++++++++
 tb/tb_and_gate_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/and_gate_sequencer.sv
// and_gate_sequencer: drives exhaustive then LFSR stimulus into an AND gate and checks y in hardware.
// Optional first-mismatch capture ports are enabled by defining SEQ_FAIL_CAPTURE_EN.
module and_gate_sequencer #(
  parameter int unsigned HOLD_CYCLES  = 5,
  parameter int unsigned RAND_VECTORS = 100,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [8:0] vec_index
`ifdef SEQ_FAIL_CAPTURE_EN
  ,
  output logic       fail_valid,
  output logic [8:0] fail_index,
  output logic       fail_a,
  output logic       fail_b,
  output logic       fail_y
`endif
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [8:0] LAST_IDX  = 9'(RAND_VECTORS + 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXH,
    S_RND,
    S_DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] hold, hold_n;
  logic [7:0] lfsr, lfsr_n, lfsr_step;
  logic [7:0] err_n;
  logic [8:0] vec_n;
  logic       a_n, b_n, busy_n, done_n;
  logic       start_ok, sample, mismatch;

  // Fibonacci taps 8,6,5,4
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign pass      = done && (err_count == 8'd0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      hold      <= 8'd0;
      lfsr      <= LFSR_SEED;
      err_count <= 8'd0;
      vec_index <= 9'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      lfsr      <= lfsr_n;
      err_count <= err_n;
      vec_index <= vec_n;
      a_out     <= a_n;
      b_out     <= b_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    hold_n   = hold;
    lfsr_n   = lfsr;
    err_n    = err_count;
    vec_n    = vec_index;
    a_n      = a_out;
    b_n      = b_out;
    busy_n   = busy;
    done_n   = done;
    start_ok = 1'b0;
    sample   = 1'b0;
    mismatch = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        // start is only looked at here, so a start coincident with DONE entry is dropped
        if (start) begin
          start_ok = 1'b1;
          state_n  = S_EXH;
          hold_n   = 8'd0;
          lfsr_n   = LFSR_SEED;
          err_n    = 8'd0;
          vec_n    = 9'd0;
          a_n      = 1'b0;
          b_n      = 1'b0;
          busy_n   = 1'b1;
          done_n   = 1'b0;
        end
      end

      S_EXH, S_RND: begin
        sample = (hold == HOLD_LAST);
        if (!sample) begin
          hold_n = hold + 8'd1;
        end else begin
          hold_n   = 8'd0;
          mismatch = (y_in != (a_out & b_out));
          if (mismatch && (err_count != 8'hFF))
            err_n = err_count + 8'd1;
          if (state == S_RND)
            lfsr_n = lfsr_step;

          if (vec_index == LAST_IDX) begin
            state_n = S_DONE;
            a_n     = 1'b0;
            b_n     = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            vec_n = vec_index + 9'd1;
            if (state == S_EXH) begin
              if (vec_index == 9'd3) begin
                // LFSR still holds the seed here: it only steps during RND
                state_n = S_RND;
                a_n     = lfsr[0];
                b_n     = lfsr[1];
              end else begin
                a_n = vec_n[1];
                b_n = vec_n[0];
              end
            end else begin
              a_n = lfsr_step[0];
              b_n = lfsr_step[1];
            end
          end
        end
      end
    endcase
  end

`ifdef SEQ_FAIL_CAPTURE_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fail_valid <= 1'b0;
      fail_index <= 9'd0;
      fail_a     <= 1'b0;
      fail_b     <= 1'b0;
      fail_y     <= 1'b0;
    end else if (start_ok) begin
      fail_valid <= 1'b0;
      fail_index <= 9'd0;
      fail_a     <= 1'b0;
      fail_b     <= 1'b0;
      fail_y     <= 1'b0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_index <= vec_index;
      fail_a     <= a_out;
      fail_b     <= b_out;
      fail_y     <= y_in;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate_sequencer.sv
// Directed bench for and_gate_sequencer: golden, stuck-at-0, mid-run reset and zero-random-vector runs.
module tb_and_gate_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic       a_out, b_out, y_in;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [8:0] vec_index;

  logic       start_z;
  logic       a_z, b_z, y_z;
  logic       busy_z, done_z, pass_z;
  logic [7:0] err_z;
  logic [8:0] vec_z;

  int mode;
  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] pat     [0:103];
  logic [1:0] exp_pat [0:103];
  int         exp_sa0;

  always #5 sys_clk = ~sys_clk;

  // 0: golden AND, 1: stuck-at-0, 2: stuck-at-1
  assign y_in = (mode == 0) ? (a_out & b_out) : (mode == 1) ? 1'b0 : 1'b1;
  assign y_z  = 1'b1;

  and_gate_sequencer #(.HOLD_CYCLES(5), .RAND_VECTORS(100), .LFSR_SEED(8'hA5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .a_out(a_out), .b_out(b_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_index(vec_index)
  );

  and_gate_sequencer #(.HOLD_CYCLES(5), .RAND_VECTORS(0), .LFSR_SEED(8'hA5)) dut_z (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_z),
    .a_out(a_z), .b_out(b_z), .y_in(y_z),
    .busy(busy_z), .done(done_z), .pass(pass_z),
    .err_count(err_z), .vec_index(vec_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    else
      n_pass++;
  endtask

  function automatic int pat_errors();
    int n = 0;
    for (int v = 0; v < 104; v++)
      if (pat[v] !== exp_pat[v]) n++;
    return n;
  endfunction

  // Pulses start, then steps one negedge per cycle until done; cycle 0 is the one after acceptance.
  task automatic run_seq(input int restart_at, output int done_cyc, output int busy_len);
    int  c;
    bit  fin;
    for (int v = 0; v < 104; v++) pat[v] = 2'bxx;
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    c        = 0;
    fin      = 1'b0;
    done_cyc = -1;
    busy_len = 0;
    while (!fin && c < 1500) begin
      if (c > 0) @(negedge sys_clk);
      if (done) begin
        done_cyc = c;
        fin      = 1'b1;
      end else begin
        if (busy) busy_len++;
        if ((c % 5) == 0 && (c / 5) < 104) pat[c / 5] = {a_out, b_out};
        start = (c == restart_at);
        c++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int         dc, bl, cz;
    logic [7:0] l;

    l       = 8'hA5;
    exp_sa0 = 1;
    for (int v = 0; v < 4; v++) exp_pat[v] = 2'(v);
    for (int v = 4; v < 104; v++) begin
      exp_pat[v] = {l[0], l[1]};
      if (l[1:0] == 2'b11) exp_sa0++;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end

    mode    = 0;
    start   = 1'b0;
    start_z = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_pass", 32'({done, pass}), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_vec", 32'(vec_index), 32'd0);
    check("rst_ab", 32'({a_out, b_out}), 32'd0);
    check("rst_z", 32'({busy_z, done_z, err_z, vec_z}), 32'd0);

    // golden run with an ignored start at cycle 200
    run_seq(200, dc, bl);
    check("gold_done_cycle", 32'(dc), 32'd520);
    check("gold_busy_len", 32'(bl), 32'd520);
    check("gold_pass", 32'({busy, done, pass}), 32'b011);
    check("gold_err", 32'(err_count), 32'd0);
    check("gold_vec", 32'(vec_index), 32'd103);
    check("gold_ab_idle", 32'({a_out, b_out}), 32'd0);
    check("order_c0", 32'(pat[0]), 32'b00);
    check("order_c5", 32'(pat[1]), 32'b01);
    check("order_c10", 32'(pat[2]), 32'b10);
    check("order_c15", 32'(pat[3]), 32'b11);
    // seed A5 -> 4A -> 95: {a,b} = {lfsr[0], lfsr[1]}
    check("rnd_v4", 32'(pat[4]), 32'b10);
    check("rnd_v5", 32'(pat[5]), 32'b01);
    check("rnd_v6", 32'(pat[6]), 32'b10);
    check("gold_pattern", 32'(pat_errors()), 32'd0);

    // stuck-at-0 gate, restarted from DONE
    mode = 1;
    run_seq(-1, dc, bl);
    check("sa0_done_cycle", 32'(dc), 32'd520);
    check("sa0_err", 32'(err_count), 32'(exp_sa0));
    check("sa0_pass", 32'(pass), 32'd0);
    check("sa0_pattern", 32'(pat_errors()), 32'd0);

    // asynchronous reset at cycle 50, then a clean rerun
    mode = 0;
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    repeat (50) @(negedge sys_clk);
    check("abort_vec_pre", 32'(vec_index), 32'd10);
    check("abort_busy_pre", 32'(busy), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vec", 32'(vec_index), 32'd0);
    check("abort_err", 32'(err_count), 32'd0);
    check("abort_out", 32'({done, pass, a_out, b_out}), 32'd0);
    @(negedge sys_clk) sys_rst = 1'b0;
    @(negedge sys_clk);
    run_seq(-1, dc, bl);
    check("rerun_done_cycle", 32'(dc), 32'd520);
    check("rerun_pattern", 32'(pat_errors()), 32'd0);
    check("rerun_pass", 32'({pass, err_count}), 32'h100);

    // RAND_VECTORS=0 instance with a stuck-at-1 gate
    @(negedge sys_clk) start_z = 1'b1;
    @(negedge sys_clk) start_z = 1'b0;
    cz = 0;
    while (!done_z && cz < 200) begin
      @(negedge sys_clk);
      cz++;
    end
    check("z_done_cycle", 32'(cz), 32'd20);
    check("z_err", 32'(err_z), 32'd3);
    check("z_pass", 32'(pass_z), 32'd0);
    check("z_vec", 32'(vec_z), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
